// File: rtl/count_sched_pkg.sv
// Shared types and constants for the count scheduler:
// FSM state encoding, requester indices and the round-robin pick.
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Single requester wins outright; with both requesting, the favoured
    // one (the requester not served last) wins.
    function automatic logic pick_winner(input logic req_a,
                                         input logic req_b,
                                         input logic favoured);
        if (req_a && req_b) begin
            return favoured;
        end else if (req_a) begin
            return REQ_A;
        end else begin
            return REQ_B;
        end
    endfunction

endpackage

// File: rtl/count_sched_if.sv
// Request/grant bundle between two requesters and the count scheduler.
// The abort input exists only when SCHED_ABORT_EN is defined.
interface count_sched_if #(
    parameter int NUM_CNT_BITS = 6
);
    logic                    req_a;
    logic                    req_b;
    logic [NUM_CNT_BITS-1:0] len_a;
    logic [NUM_CNT_BITS-1:0] len_b;
`ifdef SCHED_ABORT_EN
    logic                    abort;
`endif
    logic                    grant_a;
    logic                    grant_b;
    logic                    done_a;
    logic                    done_b;
    logic                    busy;
    logic [NUM_CNT_BITS-1:0] count_out;

`ifdef SCHED_ABORT_EN
    modport master (
        output req_a, req_b, len_a, len_b, abort,
        input  grant_a, grant_b, done_a, done_b, busy, count_out
    );

    modport slave (
        input  req_a, req_b, len_a, len_b, abort,
        output grant_a, grant_b, done_a, done_b, busy, count_out
    );
`else
    modport master (
        output req_a, req_b, len_a, len_b,
        input  grant_a, grant_b, done_a, done_b, busy, count_out
    );

    modport slave (
        input  req_a, req_b, len_a, len_b,
        output grant_a, grant_b, done_a, done_b, busy, count_out
    );
`endif

endinterface

// File: rtl/count_sched_interval_counter.sv
// Interval counter: cleared to zero on request, otherwise advances by one
// while enabled. Clear has priority over enable.
module interval_counter #(
    parameter int NUM_CNT_BITS = 6
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= count_out + NUM_CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/count_sched.sv
// Count scheduler: grants a shared interval counter to one of two
// requesters (round-robin), runs it for the winner's interval length and
// pulses that requester's done flag when the interval completes.
// Optional feature macro: SCHED_ABORT_EN (adds an abort input that
// terminates a running interval without a done pulse).
module count_sched
    import count_sched_pkg::*;
#(
    parameter int NUM_CNT_BITS = 6
) (
    input  logic          clk,
    input  logic          n_rst,
    count_sched_if.slave  bus
);

    sched_state_t            state;
    logic                    favoured;
    logic                    owner;
    logic [NUM_CNT_BITS-1:0] len_q;
    logic [NUM_CNT_BITS-1:0] cnt;
    logic                    grant_a_q;
    logic                    grant_b_q;
    logic                    done_a_q;
    logic                    done_b_q;
    logic                    busy_q;

    logic                    any_req;
    logic                    winner;
    logic [NUM_CNT_BITS-1:0] win_len;
    logic                    last_cycle;
    logic                    abort_hit;
    logic                    cnt_clear;
    logic                    cnt_en;

    // A zero length still occupies one grant cycle.
    function automatic logic [NUM_CNT_BITS-1:0] sat_len(input logic [NUM_CNT_BITS-1:0] len);
        return (len == '0) ? NUM_CNT_BITS'(1) : len;
    endfunction

    assign any_req    = bus.req_a | bus.req_b;
    assign winner     = pick_winner(bus.req_a, bus.req_b, favoured);
    assign win_len    = (winner == REQ_A) ? bus.len_a : bus.len_b;
    assign last_cycle = (cnt == (len_q - NUM_CNT_BITS'(1)));

`ifdef SCHED_ABORT_EN
    assign abort_hit = bus.abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Counter control: zero outside RUN, advance in RUN, hold on the last cycle
    // so DONE still shows the final count.
    always_comb begin
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;
        if (state == RUN && !abort_hit) begin
            cnt_clear = 1'b0;
            cnt_en    = !last_cycle;
        end
    end

    interval_counter #(
        .NUM_CNT_BITS (NUM_CNT_BITS)
    ) u_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .count_out    (cnt)
    );

    // Scheduler FSM with registered grant/done/busy outputs. The favoured
    // pointer moves to the other requester whenever an interval ends.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            busy_q    <= 1'b0;
            favoured  <= REQ_A;
        end else begin
            case (state)
                IDLE: begin
                    done_a_q <= 1'b0;
                    done_b_q <= 1'b0;
                    if (any_req) begin
                        state     <= RUN;
                        owner     <= winner;
                        len_q     <= sat_len(win_len);
                        grant_a_q <= (winner == REQ_A);
                        grant_b_q <= (winner == REQ_B);
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_hit) begin
                        state     <= IDLE;
                        grant_a_q <= 1'b0;
                        grant_b_q <= 1'b0;
                        busy_q    <= 1'b0;
                        favoured  <= ~owner;
                    end else if (last_cycle) begin
                        state     <= DONE;
                        grant_a_q <= 1'b0;
                        grant_b_q <= 1'b0;
                        done_a_q  <= (owner == REQ_A);
                        done_b_q  <= (owner == REQ_B);
                        favoured  <= ~owner;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done_a_q <= 1'b0;
                    done_b_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    grant_a_q <= 1'b0;
                    grant_b_q <= 1'b0;
                    done_a_q  <= 1'b0;
                    done_b_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_a   = grant_a_q;
    assign bus.grant_b   = grant_b_q;
    assign bus.done_a    = done_a_q;
    assign bus.done_b    = done_b_q;
    assign bus.busy      = busy_q;
    assign bus.count_out = cnt;

endmodule

// File: tb/tb_count_sched.sv
// Testbench for count_sched: directed scenarios followed by randomized
// traffic, all compared against a timestamp-based reference model.
// Abort scenarios are included when SCHED_ABORT_EN is defined.
module tb_count_sched;

    localparam int W = 6;

    logic clk = 1'b0;
    logic n_rst;
    logic abort_drv = 1'b0;

    always #5 clk = ~clk;

    count_sched_if #(.NUM_CNT_BITS(W)) bus ();

`ifdef SCHED_ABORT_EN
    assign bus.abort = abort_drv;
`endif

    count_sched #(.NUM_CNT_BITS(W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: an interval is described by its start edge, length
    // and owner; expected outputs follow from where the current edge falls.
    int edge_n  = 0;
    int e0      = 0;
    int m_len   = 1;
    int m_who   = 0;
    int free_at = 0;
    bit active  = 1'b0;
    int m_fav   = 0;

    int exp_ga, exp_gb, exp_da, exp_db, exp_busy, exp_cnt;

    // Observation statistics for the directed scenarios.
    int cnt_ga, cnt_gb, cnt_da, cnt_db, max_cnt, first_grant_edge, done_edge;
    int order[$];
    logic prev_ga = 1'b0;
    logic prev_gb = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_edge();
        int e;
        int la;
        int lb;
        edge_n++;
        e  = edge_n;
        la = int'(bus.len_a);
        lb = int'(bus.len_b);
        if (!n_rst) begin
            active  = 1'b0;
            m_fav   = 0;
            free_at = e + 1;
        end else if (active && abort_drv && (e - 1 >= e0) && (e - 1 <= e0 + m_len - 1)) begin
            active  = 1'b0;
            m_fav   = 1 - m_who;
            free_at = e + 1;
        end else if (e >= free_at && (bus.req_a || bus.req_b)) begin
            if (bus.req_a && bus.req_b) m_who = m_fav;
            else if (bus.req_a)         m_who = 0;
            else                        m_who = 1;
            m_len   = (m_who == 0) ? la : lb;
            if (m_len == 0) m_len = 1;
            e0      = e;
            free_at = e + m_len + 2;
            m_fav   = 1 - m_who;
            active  = 1'b1;
        end
        exp_ga = 0; exp_gb = 0; exp_da = 0; exp_db = 0; exp_busy = 0; exp_cnt = 0;
        if (active && e >= e0 && e < e0 + m_len) begin
            exp_ga   = (m_who == 0) ? 1 : 0;
            exp_gb   = (m_who == 1) ? 1 : 0;
            exp_busy = 1;
            exp_cnt  = e - e0;
        end else if (active && e == e0 + m_len) begin
            exp_da   = (m_who == 0) ? 1 : 0;
            exp_db   = (m_who == 1) ? 1 : 0;
            exp_busy = 1;
            exp_cnt  = m_len - 1;
        end
    endtask

    task automatic clear_stats();
        cnt_ga = 0; cnt_gb = 0; cnt_da = 0; cnt_db = 0; max_cnt = 0;
        first_grant_edge = -1; done_edge = -1;
        order.delete();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("grant_a",   int'(bus.grant_a),   exp_ga);
        check_val("grant_b",   int'(bus.grant_b),   exp_gb);
        check_val("done_a",    int'(bus.done_a),    exp_da);
        check_val("done_b",    int'(bus.done_b),    exp_db);
        check_val("busy",      int'(bus.busy),      exp_busy);
        check_val("count_out", int'(bus.count_out), exp_cnt);
        check_val("grant_excl", int'(bus.grant_a & bus.grant_b), 0);
        check_val("done_excl",  int'(bus.done_a & bus.done_b),   0);
        if (bus.grant_a) cnt_ga++;
        if (bus.grant_b) cnt_gb++;
        if (bus.done_a)  cnt_da++;
        if (bus.done_b)  cnt_db++;
        if (int'(bus.count_out) > max_cnt) max_cnt = int'(bus.count_out);
        if ((bus.grant_a && !prev_ga) || (bus.grant_b && !prev_gb)) begin
            order.push_back(bus.grant_a ? 0 : 1);
            if (first_grant_edge < 0) first_grant_edge = edge_n;
        end
        if ((bus.done_a || bus.done_b) && done_edge < 0) done_edge = edge_n;
        prev_ga = bus.grant_a;
        prev_gb = bus.grant_b;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        run(2);
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst      = 1'b0;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.len_a  = '0;
        bus.len_b  = '0;
        clear_stats();
        do_reset();

        // Single request from A, length 5; req drops while running.
        clear_stats();
        bus.req_a = 1'b1;
        bus.len_a = W'(5);
        step();
        bus.req_a = 1'b0;
        run(10);
        check_val("a5_grant_cycles", cnt_ga, 5);
        check_val("a5_done_pulses",  cnt_da, 1);
        check_val("a5_max_count",    max_cnt, 4);

        // Both held high from reset, length 3 each: A, B, A, B.
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        bus.len_a = W'(3);
        bus.len_b = W'(3);
        do_reset();
        clear_stats();
        run(22);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        run(6);
        check_val("rr_order_len", int'(order.size() >= 4), 1);
        if (order.size() >= 4) begin
            check_val("rr_order0", order[0], 0);
            check_val("rr_order1", order[1], 1);
            check_val("rr_order2", order[2], 0);
            check_val("rr_order3", order[3], 1);
        end

        // B with length 0 behaves as length 1.
        clear_stats();
        bus.req_b = 1'b1;
        bus.len_b = '0;
        step();
        bus.req_b = 1'b0;
        run(5);
        check_val("b0_grant_cycles", cnt_gb, 1);
        check_val("b0_done_pulses",  cnt_db, 1);
        check_val("b0_done_offset",  done_edge - first_grant_edge, 1);

        // Maximum length: count stops at 62 and never wraps.
        clear_stats();
        bus.req_a = 1'b1;
        bus.len_a = W'(63);
        step();
        bus.req_a = 1'b0;
        run(70);
        check_val("max_count",       max_cnt, 62);
        check_val("max_done_offset", done_edge - first_grant_edge, 63);
        check_val("max_grant_cycles", cnt_ga, 63);

        // Reset on the third grant cycle of a length-10 interval.
        clear_stats();
        bus.req_a = 1'b1;
        bus.len_a = W'(10);
        run(3);
        bus.req_a = 1'b0;
        n_rst = 1'b0;
        step();
        check_val("rst_mid_busy",  int'(bus.busy), 0);
        check_val("rst_mid_count", int'(bus.count_out), 0);
        n_rst = 1'b1;
        run(15);
        check_val("rst_mid_no_done", cnt_da, 0);

`ifdef SCHED_ABORT_EN
        // Abort on the second grant cycle of B; A then wins a tie.
        clear_stats();
        bus.req_b = 1'b1;
        bus.len_b = W'(8);
        step();
        bus.req_b = 1'b0;
        step();
        abort_drv = 1'b1;
        step();
        abort_drv = 1'b0;
        check_val("abort_grant_b", int'(bus.grant_b), 0);
        check_val("abort_busy",    int'(bus.busy), 0);
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        bus.len_a = W'(2);
        step();
        check_val("abort_then_a_wins", int'(bus.grant_a), 1);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        run(6);
        check_val("abort_no_done_b", cnt_db, 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            bus.req_a = ($urandom_range(0, 3) != 0);
            bus.req_b = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            bus.len_a = (r == 0) ? '0 : ((r < 8) ? W'($urandom_range(1, 6)) : W'($urandom_range(0, 63)));
            r = $urandom_range(0, 9);
            bus.len_b = (r == 0) ? '0 : ((r < 8) ? W'($urandom_range(1, 6)) : W'($urandom_range(0, 63)));
            n_rst = ($urandom_range(0, 79) != 0);
`ifdef SCHED_ABORT_EN
            abort_drv = ($urandom_range(0, 11) == 0);
`endif
            step();
        end
        abort_drv = 1'b0;
        n_rst     = 1'b1;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        run(70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
